serial_adder: RTL and testbench

Bit-serial multi-bit adder built around the existing 1-bit full_adder cell.
- Loads two WIDTH-bit operands and a carry-in.
- Feeds one bit pair per clock, LSB first, into a single full_adder instance, registering its carry back as the next cin.
- Presents the WIDTH-bit sum and final carry with a done pulse.
- Serves as the sequential stage that drives the combinational full adder; trades area for latency.

---
 rtl/serial_adder.sv | 135 +++++++++++++
 tb/tb_serial_adder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: streams operand bits LSB first through one full_adder cell,
// feeding the registered carry back each cycle, and publishes sum/cout with a done pulse.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, psum_q, psum_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, busy_q, busy_d, done_q, done_d, cout_q, cout_d;
  logic             fa_sum, fa_cout;
  logic [WIDTH-1:0] psum_next;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts
  if (WIDTH > 1) begin : g_wide
    assign psum_next = {fa_sum, psum_q[WIDTH-1:1]};
  end else begin : g_one
    assign psum_next = fa_sum;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          cnt_d   = {CW{1'b0}};
          psum_d  = {WIDTH{1'b0}};
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> 1'b1;
        b_d     = b_q >> 1'b1;
        psum_d  = psum_next;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = psum_next;
          cout_d  = fa_cout;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      psum_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum_out = sum_q;
  assign cout    = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random operands
// checked against plain integer addition, for WIDTH=8 and WIDTH=1.

module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst;
  logic       start, cin, busy, done, cout;
  logic [7:0] a_in, b_in, sum_out;
  logic       start1, a1, b1, cin1, busy1, done1, sum1, cout1;

  int         n_cmp = 0;
  int         n_mis = 0;
  logic [8:0] prev_res;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .sum_out(sum_out), .cout(cout)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum_out(sum1), .cout(cout1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle or in its DONE cycle; returns at the negedge where done is seen.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c, input bit hold);
    logic [8:0] exp;
    int         cyc;
    bit         seen;
    exp   = {1'b0, a} + {1'b0, b} + {8'd0, c};
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    cin   = c;
    @(posedge clk);
    #1;
    if (hold) begin
      a_in = 8'hAA;
      b_in = 8'h55;
      cin  = 1'b1;
    end else begin
      start = 1'b0;
    end
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1'b1;
      end else begin
        check_eq("busy_run", {31'd0, busy}, 32'd1);
        check_eq("result_held", {23'd0, cout, sum_out}, {23'd0, prev_res});
      end
    end
    start = 1'b0;
    check_eq("done_seen", {31'd0, seen}, 32'd1);
    check_eq("latency", cyc, 32'd9);
    check_eq("result", {23'd0, cout, sum_out}, {23'd0, exp});
    check_eq("busy_in_done", {31'd0, busy}, 32'd0);
    prev_res = exp;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check_eq("done_one_cycle", {31'd0, done}, 32'd0);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    check_eq("idle_hold", {23'd0, cout, sum_out}, {23'd0, prev_res});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_in = 8'h00; b_in = 8'h00; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    prev_res = 9'd0;
    #7;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_result", {23'd0, cout, sum_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(8'h5A, 8'h3C, 1'b0, 1'b0); idle_cycle();
    do_op(8'hFF, 8'h01, 1'b0, 1'b0); idle_cycle();
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0); idle_cycle();
    do_op(8'h10, 8'h20, 1'b0, 1'b1); idle_cycle();
    do_op(8'hAA, 8'h11, 1'b0, 1'b0);
    do_op(8'h01, 8'h01, 1'b0, 1'b0); idle_cycle();

    // Abort an addition partway through RUN with an asynchronous reset
    start = 1'b1; a_in = 8'h33; b_in = 8'h44; cin = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("async_rst_done", {31'd0, done}, 32'd0);
    check_eq("async_rst_result", {23'd0, cout, sum_out}, 32'd0);
    prev_res = 9'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("no_done_after_rst", {31'd0, done}, 32'd0);
    end
    do_op(8'h7F, 8'h01, 1'b0, 1'b0); idle_cycle();

    // WIDTH=1: exhaustive full-adder truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] exp1;
      v = i[2:0];
      exp1 = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
      start1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
      @(posedge clk);
      #1 start1 = 1'b0;
      @(negedge clk);
      check_eq("w1_busy", {31'd0, busy1}, 32'd1);
      check_eq("w1_no_done", {31'd0, done1}, 32'd0);
      @(negedge clk);
      check_eq("w1_done", {31'd0, done1}, 32'd1);
      check_eq("w1_result", {30'd0, cout1, sum1}, {30'd0, exp1});
    end

    for (int i = 0; i < 40; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
